uart_rx: RTL and testbench

Asynchronous serial receiver, the receive-side counterpart of the UART transmit path. It oversamples the incoming line, qualifies the start bit at mid-bit, and shifts in data bits LSB first. It checks the stop bit and presents each received byte as a one-cycle valid pulse on the parallel side. It sits between the pad-side `rx` pin and the core's byte consumer.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/baud_rate_gen_rx.sv | 34 +++
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, default rates and oversample divider helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int DEFAULT_CLK_FREQ   = 50_000_000;
  localparam int DEFAULT_BAUD_RATE  = 9600;
  localparam int DEFAULT_OVERSAMPLE = 16;

  // Clocks per oversample tick, truncated; the residual rate error is
  // absorbed by mid-bit sampling.
  function automatic int os_cnt_max(input int clk_freq, input int baud_rate, input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/baud_rate_gen_rx.sv
// rtl/baud_rate_gen_rx.sv - free-running oversample tick generator for the receiver
module baud_rate_gen_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic clk,
  input  logic rst_n,
  output logic os_tick
);

  localparam int OS_CNT_MAX = os_cnt_max(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CNT_W      = (OS_CNT_MAX > 1) ? $clog2(OS_CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OS_CNT_MAX - 1);

  logic [CNT_W-1:0] cnt;

  // Wrap every OS_CNT_MAX clocks and emit a single-cycle tick; never resynced to the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      os_tick <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt     <= '0;
      os_tick <= 1'b1;
    end else begin
      cnt     <= cnt + 1'b1;
      os_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver; define UART_RX_PARITY_EN for an even-parity bit
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 framing_err,
  output logic                 parity_err
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic [1:0]           sync;
  logic                 rx_s;
  logic                 os_tick;
  rx_state_t            state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  baud_rate_gen_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .os_tick(os_tick)
  );

  // Two-flop synchronizer; resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  assign rx_s = sync[1];

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_err_q;

  assign parity_err = par_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // Frame FSM: counters clear on every state change, outputs are registered single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit     <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (os_tick && !rx_s) begin
            state    <= START;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        end

        START: begin
          if (os_tick) begin
            if (tick_cnt == TICK_HALF) begin
              // Low at mid start bit is a real frame; high means a glitch.
              state    <= rx_s ? IDLE : DATA;
              tick_cnt <= '0;
              bit_cnt  <= '0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (os_tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= PARITY;
`else
                state   <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        PARITY: begin
          if (os_tick) begin
            if (tick_cnt == TICK_LAST) begin
`ifdef UART_RX_PARITY_EN
              par_bit  <= rx_s;
`endif
              state    <= STOP;
              tick_cnt <= '0;
              bit_cnt  <= '0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        STOP: begin
          if (os_tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              if (rx_s) begin
                // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
                rx_data  <= shreg;
                rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                par_err_q <= (^shreg) ^ par_bit;
`endif
                state    <= IDLE;
              end else begin
                framing_err <= 1'b1;
                state       <= WAIT_HIGH;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        WAIT_HIGH: begin
          // A held-low break stays here, so it reports only one framing error.
          if (rx_s) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        end

        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx
module tb_uart_rx;

  localparam int BIT_CLK = 64;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_err;
  logic       parity_err;

  int tests  = 0;
  int errors = 0;
  int cyc    = 0;
  int bit_cyc;
  int start_cyc;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;

  typedef struct {
    logic       ferr;
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t sb[$];

  uart_rx #(
    .CLK_FREQ  (6_400_000),
    .BAUD_RATE (100_000),
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .framing_err(framing_err),
    .parity_err (parity_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic perr);
    exp_t e;
    e.ferr = 1'b0;
    e.data = d;
    e.perr = perr;
    sb.push_back(e);
  endtask

  task automatic expect_ferr(input logic [7:0] held);
    exp_t e;
    e.ferr = 1'b1;
    e.data = held;
    e.perr = 1'b0;
    sb.push_back(e);
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    bit_cyc = cyc;
    rx = b;
    repeat (BIT_CLK - 1) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    @(negedge clk);
    rx = 1'b1;
    repeat (n * BIT_CLK - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    drive_bit(1'b0);
    start_cyc = bit_cyc;
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par) begin end
`endif
    drive_bit(stop);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a frame outcome.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && parity_err && !rx_valid) begin
      tests++;
      errors++;
      $display("FAIL parity_without_valid: got parity_err=1 rx_valid=0 expected rx_valid=1");
    end
    if (rx_valid || framing_err) begin
      if (rx_valid) begin
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
      end
      if (sb.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL unexpected_event: got valid=%0b ferr=%0b data=0x%0h expected no event",
                 rx_valid, framing_err, rx_data);
      end else begin
        e = sb.pop_front();
        check("event{ferr,valid,perr,data}",
              32'({framing_err, rx_valid, parity_err, rx_data}),
              32'({e.ferr, ~e.ferr, e.perr, e.data}));
      end
    end
  end

  initial begin
    int lat;
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_framing_err", 32'(framing_err), 32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    rst_n = 1'b1;
    idle_bits(2);

    // 1: single 0x55 frame and its latency from the start edge
    expect_byte(8'h55, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1);
    idle_bits(2);
    lat = last_valid_cyc - start_cyc;
    tests++;
    if (lat < 606 || lat > 618) begin
      errors++;
      $display("FAIL latency_0x55: got %0d clk expected 606..618 clk", lat);
    end

    // 2: back-to-back frames with no idle gap
    expect_byte(8'hA5, 1'b0);
    expect_byte(8'h3C, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b1);
    idle_bits(2);
    check("b2b_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'd640);

    // 3: quarter-bit glitch is rejected, then 0x12 is received
    @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    check("idle_after_glitch", 32'(dut.state), 32'(uart_pkg::IDLE));
    expect_byte(8'h12, 1'b0);
    send_frame(8'h12, 1'b0, 1'b1);
    idle_bits(2);

    // 4: bad stop bit then a long break -> one framing error, data held at 0x12
    expect_ferr(8'h12);
    send_frame(8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    rx = 1'b0;
    repeat (20 * BIT_CLK) @(negedge clk);
    idle_bits(2);
    check("data_held_after_ferr", 32'(rx_data), 32'h12);
    expect_byte(8'h81, 1'b0);
    send_frame(8'h81, 1'b0, 1'b1);
    idle_bits(2);

`ifdef UART_RX_PARITY_EN
    // 5: even parity on 0x07 (three ones)
    expect_byte(8'h07, 1'b1);
    send_frame(8'h07, 1'b0, 1'b1);
    idle_bits(2);
    expect_byte(8'h07, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(2);
`endif

    // 6: reset during data bit 3 aborts the frame silently
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_rx_data", 32'(rx_data), 32'h0);
    check("midreset_rx_valid", 32'(rx_valid), 32'h0);
    check("midreset_framing_err", 32'(framing_err), 32'h0);
    check("midreset_parity_err", 32'(parity_err), 32'h0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(12);
    expect_byte(8'hC3, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1);

    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    idle_bits(1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
